// File: rtl/mii_mac_pkg.sv
// Shared types for the MAC TX path.
// The frame FIFO entry layout and pointer-width helper live here.
package mii_mac_pkg;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } fifo_entry_t;

  typedef enum logic {
    ST_ACCEPT  = 1'b0,
    ST_DISCARD = 1'b1
  } wr_state_t;

  // Pointers carry one extra wrap bit above the address.
  function automatic int fifo_ptr_w(input int depth_bits);
    return depth_bits + 1;
  endfunction

  localparam int FIFO_PTR_W = fifo_ptr_w(11);

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM.
// One write port and one registered read port.
module sdp_ram #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 9
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/axis_tx_frame_fifo.sv
// Store-and-forward TX frame FIFO ahead of the CRC-append stage.
// Frames are released only once complete; bad or oversize frames vanish.
module axis_tx_frame_fifo
  import mii_mac_pkg::*;
#(
  parameter int DEPTH_BITS    = 11,
  parameter bit DROP_ON_TUSER = 1'b1
) (
  input  logic       clock,
  input  logic       aresetn,
  input  logic [7:0] saxis_tdata,
  input  logic       saxis_tvalid,
  output logic       saxis_tready,
  input  logic       saxis_tuser,
  input  logic       saxis_tlast,
  output logic [7:0] maxis_tdata,
  output logic       maxis_tvalid,
  input  logic       maxis_tready,
  output logic       maxis_tuser,
  output logic       maxis_tlast,
  output logic       drop_error,
  output logic       drop_oversize
);

  localparam int PW = fifo_ptr_w(DEPTH_BITS);
  localparam logic [PW-1:0] CAP = {1'b0, {DEPTH_BITS{1'b1}}};
  localparam logic [PW-1:0] ONE = PW'(1);

  wr_state_t   state_q, state_d;
  logic [PW-1:0] wr_ptr, wr_ptr_d;
  logic [PW-1:0] commit_ptr, commit_ptr_d;
  logic [PW-1:0] rd_ptr;
  logic        full, wr_en;
  logic        drop_err_d, drop_ovs_d;
  fifo_entry_t wr_entry, rd_q, ob0, ob1;
  logic [1:0]  ob_cnt;
  logic        rd_pend, rd_en, avail, pop;

  assign full     = (wr_ptr - rd_ptr) == CAP;
  assign wr_entry = '{last: saxis_tlast, data: saxis_tdata};

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr;
    commit_ptr_d = commit_ptr;
    drop_err_d   = 1'b0;
    drop_ovs_d   = 1'b0;
    saxis_tready = 1'b0;
    wr_en        = 1'b0;
    unique case (state_q)
      ST_ACCEPT: begin
        saxis_tready = aresetn && !full;
        // A frame that alone fills the buffer can never commit.
        if (full && (wr_ptr - commit_ptr) == CAP) begin
          wr_ptr_d   = commit_ptr;
          state_d    = ST_DISCARD;
          drop_ovs_d = 1'b1;
        end else if (saxis_tvalid && saxis_tready) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr + ONE;
          if (saxis_tlast) begin
            if (DROP_ON_TUSER && saxis_tuser) begin
              wr_ptr_d   = commit_ptr;
              drop_err_d = 1'b1;
            end else begin
              commit_ptr_d = wr_ptr + ONE;
            end
          end
        end
      end
      ST_DISCARD: begin
        saxis_tready = aresetn;
        if (saxis_tvalid && saxis_tlast) state_d = ST_ACCEPT;
      end
      default: state_d = ST_ACCEPT;
    endcase
  end

  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= ST_ACCEPT;
      wr_ptr        <= '0;
      commit_ptr    <= '0;
      drop_error    <= 1'b0;
      drop_oversize <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr        <= wr_ptr_d;
      commit_ptr    <= commit_ptr_d;
      drop_error    <= drop_err_d;
      drop_oversize <= drop_ovs_d;
    end
  end

  sdp_ram #(
    .ADDR_W(DEPTH_BITS),
    .DATA_W($bits(fifo_entry_t))
  ) u_ram (
    .clock  (clock),
    .wr_en  (wr_en),
    .wr_addr(wr_ptr[DEPTH_BITS-1:0]),
    .wr_data(wr_entry),
    .rd_en  (rd_en),
    .rd_addr(rd_ptr[DEPTH_BITS-1:0]),
    .rd_data(rd_q)
  );

  assign avail = rd_ptr != commit_ptr;
  assign pop   = maxis_tvalid && maxis_tready;
  // Never have more bytes in flight than the skid can absorb.
  assign rd_en = avail &&
    ((3'(ob_cnt) + 3'(rd_pend)) < (3'd2 + 3'(pop)));

  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      rd_ptr  <= '0;
      rd_pend <= 1'b0;
      ob_cnt  <= 2'd0;
      ob0     <= '0;
      ob1     <= '0;
    end else begin
      rd_pend <= rd_en;
      if (rd_en) rd_ptr <= rd_ptr + ONE;
      unique case ({rd_pend, pop})
        2'b10: begin
          if (ob_cnt == 2'd0) ob0 <= rd_q;
          else ob1 <= rd_q;
          ob_cnt <= ob_cnt + 2'd1;
        end
        2'b01: begin
          ob0    <= ob1;
          ob_cnt <= ob_cnt - 2'd1;
        end
        2'b11: begin
          if (ob_cnt == 2'd1) begin
            ob0 <= rd_q;
          end else begin
            ob0 <= ob1;
            ob1 <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign maxis_tvalid = ob_cnt != 2'd0;
  assign maxis_tdata  = ob0.data;
  assign maxis_tlast  = ob0.last;
  assign maxis_tuser  = 1'b0;

endmodule

// File: tb/tb_axis_tx_frame_fifo.sv
// Bench for axis_tx_frame_fifo: a large and a small instance,
// driven one at a time, checked against a frame-level model.
module tb_axis_tx_frame_fifo;

  typedef logic [8:0] beat_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       aresetn = 1'b0;
  logic [7:0] s_tdata = 8'h00;
  logic       s_tvalid = 1'b0;
  logic       s_tuser = 1'b0;
  logic       s_tlast = 1'b0;
  logic       sel = 1'b0;
  logic       m_rdy_cmd = 1'b1;
  logic       rand_rdy = 1'b0;
  logic       rnd_bit = 1'b0;
  logic       m_tready;

  logic       b_s_tready, b_m_tvalid, b_m_tuser, b_m_tlast, b_err, b_ovs;
  logic [7:0] b_m_tdata;
  logic       t_s_tready, t_m_tvalid, t_m_tuser, t_m_tlast, t_err, t_ovs;
  logic [7:0] t_m_tdata;

  logic       s_tready, m_tvalid, m_tuser, m_tlast, d_err, d_ovs;
  logic [7:0] m_tdata;

  int checks = 0;
  int errors = 0;

  assign m_tready = rand_rdy ? rnd_bit : m_rdy_cmd;

  axis_tx_frame_fifo #(.DEPTH_BITS(11), .DROP_ON_TUSER(1'b1)) dut_big (
    .clock        (clock),
    .aresetn      (aresetn),
    .saxis_tdata  (s_tdata),
    .saxis_tvalid (s_tvalid && !sel),
    .saxis_tready (b_s_tready),
    .saxis_tuser  (s_tuser),
    .saxis_tlast  (s_tlast),
    .maxis_tdata  (b_m_tdata),
    .maxis_tvalid (b_m_tvalid),
    .maxis_tready (m_tready && !sel),
    .maxis_tuser  (b_m_tuser),
    .maxis_tlast  (b_m_tlast),
    .drop_error   (b_err),
    .drop_oversize(b_ovs)
  );

  axis_tx_frame_fifo #(.DEPTH_BITS(6), .DROP_ON_TUSER(1'b1)) dut_small (
    .clock        (clock),
    .aresetn      (aresetn),
    .saxis_tdata  (s_tdata),
    .saxis_tvalid (s_tvalid && sel),
    .saxis_tready (t_s_tready),
    .saxis_tuser  (s_tuser),
    .saxis_tlast  (s_tlast),
    .maxis_tdata  (t_m_tdata),
    .maxis_tvalid (t_m_tvalid),
    .maxis_tready (m_tready && sel),
    .maxis_tuser  (t_m_tuser),
    .maxis_tlast  (t_m_tlast),
    .drop_error   (t_err),
    .drop_oversize(t_ovs)
  );

  assign s_tready = sel ? t_s_tready : b_s_tready;
  assign m_tvalid = sel ? t_m_tvalid : b_m_tvalid;
  assign m_tdata  = sel ? t_m_tdata  : b_m_tdata;
  assign m_tlast  = sel ? t_m_tlast  : b_m_tlast;
  assign m_tuser  = sel ? t_m_tuser  : b_m_tuser;
  assign d_err    = sel ? t_err      : b_err;
  assign d_ovs    = sel ? t_ovs      : b_ovs;

  always @(posedge clock) begin
    #1;
    rnd_bit <= 1'($urandom_range(0, 1));
  end

  // Output monitor: records accepted beats, pulses and stall stability.
  beat_t rx[$];
  int    err_pulses = 0;
  int    ovs_pulses = 0;
  int    unstable = 0;
  logic  prev_stall = 1'b0;
  beat_t prev_beat = '0;

  always @(negedge clock) begin
    if (!aresetn) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && (!m_tvalid || {m_tlast, m_tdata} != prev_beat))
        unstable <= unstable + 1;
      if (m_tvalid && m_tready) rx.push_back({m_tlast, m_tdata});
      prev_stall <= m_tvalid && !m_tready;
      prev_beat  <= {m_tlast, m_tdata};
      if (d_err) err_pulses <= err_pulses + 1;
      if (d_ovs) ovs_pulses <= ovs_pulses + 1;
    end
  end

  task automatic apply_reset();
    s_tvalid = 1'b0;
    aresetn  = 1'b0;
    repeat (2) @(posedge clock);
    #1 aresetn = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last,
                           input logic user, output int stalls);
    bit done;
    done = 0;
    stalls = 0;
    s_tdata = d;
    s_tlast = last;
    s_tuser = user;
    s_tvalid = 1'b1;
    while (!done) begin
      @(negedge clock);
      if (s_tready) done = 1;
      else stalls++;
      @(posedge clock);
      #1;
      if (!done && stalls > 5000) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: byte %0h stalled %0d cycles, want < 5000",
                 d, stalls);
        done = 1;
      end
    end
    s_tvalid = 1'b0;
  endtask

  task automatic wait_rx(input int want, input int budget);
    int n;
    n = 0;
    while (rx.size() < want && n < budget) begin
      @(posedge clock);
      n++;
    end
    #1;
  endtask

  task automatic test_reset();
    sel = 1'b0;
    aresetn = 1'b0;
    s_tvalid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({s_tready, m_tvalid, m_tlast, m_tdata, d_err, d_ovs} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0",
               {s_tready, m_tvalid, m_tlast, m_tdata, d_err, d_ovs});
    end
    aresetn = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: tready=%b tvalid=%b want 1/0",
               s_tready, m_tvalid);
    end
  endtask

  task automatic test_single_frame();
    int st, base, e0, o0, bad;
    sel = 1'b0;
    m_rdy_cmd = 1'b1;
    apply_reset();
    base = rx.size();
    e0 = err_pulses;
    o0 = ovs_pulses;
    for (int i = 0; i < 64; i++) send_byte(8'(i), i == 63, 1'b0, st);
    checks++;
    if (rx.size() != base || m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL early_output: got %0d beats tvalid=%b want 0/0",
               rx.size() - base, m_tvalid);
    end
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 8'h00 || m_tuser !== 1'b0) begin
      errors++;
      $display("FAIL first_latency: tvalid=%b data=%0h user=%b want 1/00/0",
               m_tvalid, m_tdata, m_tuser);
    end
    wait_rx(base + 64, 300);
    repeat (10) @(posedge clock);
    #1;
    checks++;
    if (rx.size() - base != 64) begin
      errors++;
      $display("FAIL frame64_len: got %0d want 64", rx.size() - base);
    end
    bad = 0;
    for (int i = 0; i < 64 && base + i < rx.size(); i++)
      if (rx[base+i] !== {i == 63, 8'(i)}) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL frame64_data: got %0d wrong beats want 0", bad);
    end
    checks++;
    if (err_pulses != e0 || ovs_pulses != o0) begin
      errors++;
      $display("FAIL frame64_pulses: got %0d/%0d want 0/0",
               err_pulses - e0, ovs_pulses - o0);
    end
  endtask

  task automatic test_drop_error();
    int st, base, e0, o0, bad;
    sel = 1'b0;
    m_rdy_cmd = 1'b1;
    apply_reset();
    base = rx.size();
    e0 = err_pulses;
    o0 = ovs_pulses;
    for (int i = 0; i < 10; i++) send_byte(8'(8'h50 + i), i == 9, i == 9, st);
    for (int i = 0; i < 5; i++) send_byte(8'(8'hA0 + i), i == 4, 1'b0, st);
    wait_rx(base + 5, 100);
    repeat (20) @(posedge clock);
    #1;
    checks++;
    if (err_pulses - e0 != 1 || ovs_pulses != o0) begin
      errors++;
      $display("FAIL drop_err_pulse: got %0d/%0d want 1/0",
               err_pulses - e0, ovs_pulses - o0);
    end
    checks++;
    if (rx.size() - base != 5) begin
      errors++;
      $display("FAIL drop_err_len: got %0d want 5", rx.size() - base);
    end
    bad = 0;
    for (int i = 0; i < 5 && base + i < rx.size(); i++)
      if (rx[base+i] !== {i == 4, 8'(8'hA0 + i)}) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL drop_err_data: got %0d wrong beats want 0", bad);
    end
    checks++;
    if (m_tvalid !== 1'b0 || s_tready !== 1'b1) begin
      errors++;
      $display("FAIL drop_err_idle: tvalid=%b tready=%b want 0/1",
               m_tvalid, s_tready);
    end
  endtask

  task automatic test_oversize();
    int st, late, base, e0, o0, bad, len;
    sel = 1'b1;
    m_rdy_cmd = 1'b1;
    apply_reset();
    base = rx.size();
    e0 = err_pulses;
    o0 = ovs_pulses;
    late = 0;
    len = 100;
    for (int i = 0; i < len; i++) begin
      send_byte(8'(i), i == len - 1, 1'b0, st);
      if (i >= 64) late += st;
      if (i == 62) begin
        checks++;
        if (ovs_pulses != o0) begin
          errors++;
          $display("FAIL ovs_early: got %0d pulses want 0", ovs_pulses - o0);
        end
      end
      if (i == 63) begin
        checks++;
        if (ovs_pulses - o0 != 1) begin
          errors++;
          $display("FAIL ovs_at_63: got %0d pulses want 1", ovs_pulses - o0);
        end
      end
    end
    checks++;
    if (late != 0) begin
      errors++;
      $display("FAIL ovs_discard_ready: got %0d stalls want 0", late);
    end
    repeat (20) @(posedge clock);
    #1;
    checks++;
    if (rx.size() != base || ovs_pulses - o0 != 1 || err_pulses != e0) begin
      errors++;
      $display("FAIL ovs_dropped: beats=%0d ovs=%0d err=%0d want 0/1/0",
               rx.size() - base, ovs_pulses - o0, err_pulses - e0);
    end
    for (int i = 0; i < 20; i++) send_byte(8'(8'h40 + i), i == 19, 1'b0, st);
    wait_rx(base + 20, 100);
    repeat (10) @(posedge clock);
    #1;
    bad = 0;
    for (int i = 0; i < 20 && base + i < rx.size(); i++)
      if (rx[base+i] !== {i == 19, 8'(8'h40 + i)}) bad++;
    checks++;
    if (rx.size() - base != 20 || bad != 0) begin
      errors++;
      $display("FAIL ovs_next_frame: len=%0d bad=%0d want 20/0",
               rx.size() - base, bad);
    end
  endtask

  task automatic test_backpressure();
    int st, base, e0, o0, bad, held;
    beat_t exp[$];
    sel = 1'b1;
    m_rdy_cmd = 1'b0;
    apply_reset();
    base = rx.size();
    e0 = err_pulses;
    o0 = ovs_pulses;
    for (int f = 0; f < 4; f++)
      for (int i = 0; i < 20; i++)
        exp.push_back({i == 19, 8'(8'h10 + 32 * f + i)});
    for (int k = 0; k < 65; k++) begin
      send_byte(exp[k][7:0], exp[k][8], 1'b0, st);
      // two bytes sit in the output skid, so RAM holds k+1-2
      if (k == 63) begin
        checks++;
        if (s_tready !== 1'b1) begin
          errors++;
          $display("FAIL bp_62: tready=%b want 1", s_tready);
        end
      end
    end
    held = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (s_tready === 1'b1) held++;
    end
    checks++;
    if (held != 0) begin
      errors++;
      $display("FAIL bp_full: tready high %0d cycles want 0", held);
    end
    checks++;
    if (err_pulses != e0 || ovs_pulses != o0 || rx.size() != base) begin
      errors++;
      $display("FAIL bp_no_drop: err=%0d ovs=%0d beats=%0d want 0/0/0",
               err_pulses - e0, ovs_pulses - o0, rx.size() - base);
    end
    @(posedge clock);
    #1 m_rdy_cmd = 1'b1;
    for (int k = 65; k < 80; k++) send_byte(exp[k][7:0], exp[k][8], 1'b0, st);
    wait_rx(base + 80, 300);
    repeat (10) @(posedge clock);
    #1;
    bad = 0;
    for (int i = 0; i < 80 && base + i < rx.size(); i++)
      if (rx[base+i] !== exp[i]) bad++;
    checks++;
    if (rx.size() - base != 80 || bad != 0) begin
      errors++;
      $display("FAIL bp_drain: len=%0d bad=%0d want 80/0",
               rx.size() - base, bad);
    end
  endtask

  task automatic test_random();
    int st, base, e0, o0, u0, bad, drops, len;
    logic user;
    logic [7:0] d;
    beat_t exp[$];
    beat_t frame[$];
    sel = 1'b1;
    apply_reset();
    rand_rdy = 1'b1;
    base = rx.size();
    e0 = err_pulses;
    o0 = ovs_pulses;
    u0 = unstable;
    drops = 0;
    for (int f = 0; f < 200; f++) begin
      len = $urandom_range(1, 60);
      user = ($urandom_range(0, 9) == 0);
      frame.delete();
      for (int i = 0; i < len; i++) begin
        d = 8'($urandom);
        frame.push_back({i == len - 1, d});
        send_byte(d, i == len - 1,
                  (i == len - 1) ? user : 1'($urandom_range(0, 1)), st);
      end
      // a frame survives unless marked bad or larger than 63 usable entries
      if (user || len > 63) drops++;
      else foreach (frame[j]) exp.push_back(frame[j]);
    end
    wait_rx(base + exp.size(), 20000);
    repeat (20) @(posedge clock);
    #1;
    rand_rdy = 1'b0;
    checks++;
    if (rx.size() - base != exp.size()) begin
      errors++;
      $display("FAIL rand_len: got %0d want %0d", rx.size() - base, exp.size());
    end
    bad = 0;
    for (int i = 0; i < exp.size() && base + i < rx.size(); i++)
      if (rx[base+i] !== exp[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rand_data: got %0d wrong beats want 0", bad);
    end
    checks++;
    if (unstable != u0) begin
      errors++;
      $display("FAIL rand_stable: got %0d violations want 0", unstable - u0);
    end
    checks++;
    if (err_pulses - e0 != drops || ovs_pulses != o0) begin
      errors++;
      $display("FAIL rand_pulses: err=%0d ovs=%0d want %0d/0",
               err_pulses - e0, ovs_pulses - o0, drops);
    end
  endtask

  task automatic test_reset_midframe();
    int st, base, bad;
    sel = 1'b0;
    m_rdy_cmd = 1'b1;
    apply_reset();
    for (int i = 0; i < 30; i++) send_byte(8'(8'h80 + i), i == 29, 1'b0, st);
    for (int i = 0; i < 10; i++) send_byte(8'(8'h20 + i), 1'b0, 1'b0, st);
    checks++;
    if (m_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL mid_readout: tvalid=%b want 1", m_tvalid);
    end
    aresetn = 1'b0;
    #1;
    checks++;
    if ({s_tready, m_tvalid, m_tlast, m_tdata, d_err, d_ovs} !== 13'd0) begin
      errors++;
      $display("FAIL async_reset: got %b want 0",
               {s_tready, m_tvalid, m_tlast, m_tdata, d_err, d_ovs});
    end
    repeat (2) @(posedge clock);
    #1 aresetn = 1'b1;
    @(posedge clock);
    #1;
    base = rx.size();
    for (int i = 0; i < 8; i++) send_byte(8'(8'hC8 + i), i == 7, 1'b0, st);
    wait_rx(base + 8, 100);
    repeat (40) @(posedge clock);
    #1;
    bad = 0;
    for (int i = 0; i < 8 && base + i < rx.size(); i++)
      if (rx[base+i] !== {i == 7, 8'(8'hC8 + i)}) bad++;
    checks++;
    if (rx.size() - base != 8 || bad != 0) begin
      errors++;
      $display("FAIL post_reset_frame: len=%0d bad=%0d want 8/0",
               rx.size() - base, bad);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_drop_error();
    test_oversize();
    test_backpressure();
    test_random();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
